// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Purpose:
//   Shares one UART_TX byte transmitter between three byte sources:
//   camera-init log bytes (highest priority), status/telemetry bytes, and the
//   camera frame-byte stream (lowest priority). Frame bytes have no
//   backpressure, so they are buffered in a small circular FIFO.
//   The block owns the tx_start/tx_finish handshake with UART_TX. tx_finish
//   comes from the clk_uart domain and is resynchronised before use.
//
// Ports:
//   sys_clk, rst_n          system clock, asynchronous active-low reset
//   init_valid/data/ready   init byte source (valid held until accepted)
//   sts_valid/data/ready    status byte source (valid held until accepted)
//   frm_valid/data          frame byte strobe, no backpressure
//   fifo_full               frame FIFO full; a strobe in this cycle is dropped
//   tx_start, tx_data       request and byte to UART_TX
//   tx_finish               UART_TX idle flag (1=idle, 0=busy), async domain
//   busy                    scheduler FSM not in IDLE
//   timeout_err             sticky; set whenever a handshake phase is aborted
//   drop_cnt[15:0]          saturating count of dropped frame strobes
//                           (only with UART_TX_SCHED_DROPCNT_EN defined)
//
// Configuration macro:
//   UART_TX_SCHED_DROPCNT_EN  adds the drop_cnt output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_sched #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        init_valid,
    input  logic [7:0]  init_data,
    output logic        init_ready,
    input  logic        sts_valid,
    input  logic [7:0]  sts_data,
    output logic        sts_ready,
    input  logic        frm_valid,
    input  logic [7:0]  frm_data,
    output logic        fifo_full,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_finish,
    output logic        busy,
    output logic        timeout_err
`ifdef UART_TX_SCHED_DROPCNT_EN
   ,output logic [15:0] drop_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // tx_finish synchroniser. Reset to 1 so the FSM sees an idle transmitter
    // straight out of reset rather than a spurious busy phase.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_fin_sync;
    logic                   w_fin_s;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fin_sync <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value; blocking here would collapse
            // the synchroniser chain into a single stage.
            r_fin_sync <= {r_fin_sync[SYNC_STAGES-2:0], tx_finish};
        end
    end

    assign w_fin_s = r_fin_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Frame-byte FIFO
    // -------------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    // Full is taken from the start-of-cycle count, so a simultaneous pop does
    // not make room for a strobe arriving in the same cycle.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = frm_valid & ~w_full;

    // NOTE: the storage array carries no reset; only pointers and count do,
    // which is enough to make the FIFO empty and keeps the array a plain RAM.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= frm_data;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Scheduler FSM
    // -------------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_tx_data;
    logic [7:0]    w_tx_data_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout_err;
    logic          w_take_init;
    logic          w_take_sts;
    logic          w_take_fifo;
    logic          w_tmo;
    logic          w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        w_state_nxt   = r_state;
        w_tx_data_nxt = r_tx_data;
        w_take_init   = 1'b0;
        w_take_sts    = 1'b0;
        w_take_fifo   = 1'b0;
        w_tmo         = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (init_valid) begin
                    w_take_init   = 1'b1;
                    w_tx_data_nxt = init_data;
                    w_state_nxt   = S_START;
                end else if (sts_valid) begin
                    w_take_sts    = 1'b1;
                    w_tx_data_nxt = sts_data;
                    w_state_nxt   = S_START;
                end else if (!w_empty) begin
                    w_take_fifo   = 1'b1;
                    w_tx_data_nxt = r_mem[r_rd_ptr];
                    w_state_nxt   = S_START;
                end
            end
            S_START: begin
                // A completed handshake wins over a timeout in the same cycle.
                if (!w_fin_s) begin
                    w_state_nxt = S_DONE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                    w_tmo       = 1'b1;
                end
            end
            S_DONE: begin
                if (w_fin_s) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                    w_tmo       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_pop = w_take_fifo;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tx_data     <= 8'h00;
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_data <= w_tx_data_nxt;
            // Restart the phase timer on every state change, so it times
            // START and DONE separately.
            if (w_state_nxt != r_state) begin
                r_tmo_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
            if (w_tmo) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

`ifdef UART_TX_SCHED_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 16'h0000;
        end else if (frm_valid && w_full && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign init_ready  = w_take_init;
    assign sts_ready   = w_take_sts;
    assign fifo_full   = w_full;
    assign tx_start    = (r_state == S_START);
    assign tx_data     = r_tx_data;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout_err;

endmodule
